// File: rtl/mem_port_arbiter4_if.sv
// Bundle of request/address inputs and granted memory-port outputs for the
// four-way shared address port arbiter.
interface mem_port_arbiter4_if #(
    parameter int WIDTH = 16
);
    logic [3:0]       req;
    logic [WIDTH-1:0] addr0;
    logic [WIDTH-1:0] addr1;
    logic [WIDTH-1:0] addr2;
    logic [WIDTH-1:0] addr3;
    logic [3:0]       we;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_we;
    logic             busy;

    modport master (
        output req, addr0, addr1, addr2, addr3, we,
        input  gnt, sel, mem_addr, mem_we, busy
    );

    modport slave (
        input  req, addr0, addr1, addr2, addr3, we,
        output gnt, sel, mem_addr, mem_we, busy
    );
endinterface

// File: rtl/mem_port_arbiter4.sv
// Round-robin arbiter for the shared memory address port: four requesters,
// each ownership capped at MAX_HOLD consecutive cycles, no bubble between owners.
module mem_port_arbiter4 #(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter4_if.slave   bus
);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q;
    logic [1:0]      owner_q;
    logic [1:0]      last_q;
    logic [HW-1:0]   hold_cnt_q;
    logic [WIDTH-1:0] addr_arr [4];
    logic            busy;

    // Nearest set bit after p, wrapping so that p itself is scanned last.
    function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = p;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (v[idx]) rr_pick = idx;
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= 2'd0;
            last_q     <= 2'd3;
            hold_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        state_q    <= GRANT;
                        owner_q    <= rr_pick(bus.req, last_q);
                        hold_cnt_q <= '0;
                    end
                end
                GRANT: begin
                    if (bus.req[owner_q] && (hold_cnt_q < HOLD_LAST)) begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end else begin
                        last_q <= owner_q;
                        if (|bus.req) begin
                            owner_q    <= rr_pick(bus.req, owner_q);
                            hold_cnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = (state_q == GRANT);
    assign addr_arr[0] = bus.addr0;
    assign addr_arr[1] = bus.addr1;
    assign addr_arr[2] = bus.addr2;
    assign addr_arr[3] = bus.addr3;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_gnt
            assign bus.gnt[gi] = busy && (owner_q == 2'(gi));
        end
    endgenerate

    // sel follows owner even when idle, so it keeps the last owner's index.
    assign bus.sel      = owner_q;
    assign bus.busy     = busy;
    assign bus.mem_addr = busy ? addr_arr[owner_q] : '0;
    assign bus.mem_we   = busy & bus.we[owner_q];
endmodule

// File: doc/mem_port_arbiter4.md
Name: mem_port_arbiter4

Overview:
- Round-robin arbiter and sequencer for the shared 16-bit memory address port of the memory-to-memory vector processor.
- Four requesters share the port: 0 = instruction fetch, 1 = vector source A, 2 = vector source B, 3 = vector destination write.
- The block owns the 2-bit select of the 4:1 16-bit address mux and drives the muxed address and write-enable to memory.
- Each grant is capped at MAX_HOLD consecutive cycles so that long vector bursts cannot starve fetch.

Parameters:
- WIDTH, 16, width of each address input and of mem_addr.
- MAX_HOLD, 8, maximum consecutive granted cycles per ownership; legal range 2..256.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  per-requester access request; bit i belongs to requester i.
- addr0  input  WIDTH  address from requester 0.
- addr1  input  WIDTH  address from requester 1.
- addr2  input  WIDTH  address from requester 2.
- addr3  input  WIDTH  address from requester 3.
- we  input  4  per-requester write enable; only meaningful while that requester holds the grant.
- gnt  output  4  one-hot grant; all zero when idle.
- sel  output  2  mux select, equal to the current owner index.
- mem_addr  output  WIDTH  address of the owner while granted; 0 when idle.
- mem_we  output  1  we[owner] while granted; 0 when idle.
- busy  output  1  high while in GRANT.

Behaviour:
- Registers:
  - state: IDLE or GRANT.
  - owner[1:0].
  - last[1:0]: most recent owner.
  - hold_cnt: $clog2(MAX_HOLD) bits.
- Reset values (clk edge with reset=1):
  - state=IDLE, owner=0, last=3, hold_cnt=0.
  - Outputs: gnt=0, sel=0, busy=0, mem_addr=0, mem_we=0.
  - Because last=3, requester 0 has highest priority first.
- Reset mid-grant: ownership is dropped on that edge; outputs are at reset values the following cycle. There is no partial-burst memory.
- Outputs are combinational from registers only (gnt, sel, busy) or from registers plus address/we inputs (mem_addr, mem_we). There is no combinational path from req to any output.
- RR pick(v, p): the first set bit of v scanning indices p+1, p+2, p+3, p+4 (mod 4). Result is undefined if v=0.
- IDLE:
  - If req!=0: state<=GRANT, owner<=pick(req,last), hold_cnt<=0.
  - Latency: req high in cycle N gives gnt in cycle N+1.
  - If req=0: remain in IDLE; sel holds its last value.
- GRANT, evaluated each edge:
  - Keep: req[owner]=1 and hold_cnt<MAX_HOLD-1. Then hold_cnt<=hold_cnt+1 and owner is unchanged.
  - Release otherwise, i.e. the owner dropped req, or the owner's grant expired (hold_cnt=MAX_HOLD-1).
- On release:
  - last<=owner.
  - If req!=0: owner<=pick(req,owner), hold_cnt<=0, stay in GRANT. There is no idle bubble between owners.
  - If req=0: state<=IDLE.
  - On expiry the current owner is scanned last. If it is the only requester it is re-granted with hold_cnt=0, again with no bubble.
- Grant guarantees:
  - The owner receives at most MAX_HOLD consecutive cycles.
  - Any continuously requesting requester is granted within 3*MAX_HOLD+1 cycles.
- Simultaneous events:
  - Drop of req[owner] and new requests on the same edge: a single release and pick, using the req sampled that edge.
  - Requester changes on addr/we take effect combinationally while granted.
- Requester contract: hold req high until gnt is seen. A request withdrawn before grant is simply not served. A granted requester that drops req loses ownership at that edge; the cycle it dropped is not a memory access.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> gnt=0, busy=0, mem_addr=0, mem_we=0, sel=0 every cycle.
- req=4'b1111 held from cycle 0 with MAX_HOLD=8 -> gnt=0001 on cycles 1-8, 0010 on 9-16, 0100 on 17-24, 1000 on 25-32, 0001 again at 33; no zero-grant cycle between owners.
- Only req[2] held for 20 cycles, addr2=16'hA5A0, we=4'b0100 -> gnt=0100 continuously from cycle 1; mem_addr=A5A0, mem_we=1, sel=2 throughout; re-grant at expiry with no bubble.
- req[1] granted; drop req[1] after 3 granted cycles while req[3] is asserted on the same edge -> next cycle gnt=1000, sel=3, mem_addr=addr3; last=1.
- req[0] and req[3] rise together from IDLE right after reset -> gnt=0001. On release of 0, gnt=1000 next cycle even if req[0] is re-raised.
- Assert reset during cycle 4 of a grant to requester 1 -> next cycle all outputs zero. With req=4'b0110 still high after reset releases, gnt=0010 one cycle after reset deasserts.
